microsequencer_wcs: RTL

- Parametrised successor to the control-unit microstore: a writable control store plus a registered microinstruction register (MIR) and a next-address sequencer.
- Sits in the control unit between the instruction decoder (dispatch address, condition flags) and the datapath (control word).
- Adds what a fixed lookup store lacks: a run/halt state machine, conditional branching, opcode dispatch, a micro-subroutine return stack, stall, and a load port for reprogramming.

---
 rtl/microsequencer_wcs.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/microsequencer_wcs.sv
// Writable-control-store microsequencer: microstore, microinstruction register,
// next-address sequencer with return stack, run/halt control and a load port.
module microsequencer_wcs #(
    parameter int  ADDR_W  = 7,
    parameter int  CTRL_W  = 32,
    parameter int  STACK_D = 4,
    localparam int W       = CTRL_W + 6 + ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stall,
    input  logic [ADDR_W-1:0] dispatch_addr,
    input  logic [6:0]        cond_in,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [W-1:0]      ld_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [ADDR_W-1:0] upc,
    output logic              halted,
    output logic [2:0]        err
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam int              SP_W    = $clog2(STACK_D + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_D);

    typedef enum logic {
        HALTED = 1'b0,
        RUN    = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        NS_INC  = 3'b000,
        NS_JMP  = 3'b001,
        NS_CBR  = 3'b010,
        NS_DISP = 3'b011,
        NS_CALL = 3'b100,
        NS_RET  = 3'b101,
        NS_WAIT = 3'b110,
        NS_HALT = 3'b111
    } seq_op_t;

    state_t            state, state_nxt;
    logic [W-1:0]      store [DEPTH];
    logic [W-1:0]      mir;
    logic [W-1:0]      fetch_word;
    logic [ADDR_W-1:0] stack [2**SP_W];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_dec;
    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] nxt;
    logic [CTRL_W-1:0] mir_ctrl;
    seq_op_t           mir_ns;
    logic [2:0]        mir_cs;
    logic [ADDR_W-1:0] mir_cr;
    logic [7:0]        cond_ext;
    logic              cond;
    logic              advance;
    logic              push;
    logic              pop;
    logic              ovf;
    logic              unf;
    logic              launch;
    logic              store_we;
    logic              ld_run;

    assign mir_ctrl = mir[W-1 -: CTRL_W];
    assign mir_ns   = seq_op_t'(mir[5+ADDR_W -: 3]);
    assign mir_cs   = mir[2+ADDR_W -: 3];
    assign mir_cr   = mir[ADDR_W-1:0];

    // CS=0 selects the constant-true slot, CS=k selects cond_in[k-1].
    assign cond_ext = {cond_in, 1'b1};
    assign cond     = cond_ext[mir_cs];

    assign upc_inc  = upc + ADDR_W'(1);
    assign sp_dec   = sp - SP_W'(1);
    assign launch   = (state == HALTED) && start;
    assign store_we = reset_n && ld_en && (state == HALTED);
    assign ld_run   = ld_en && (state == RUN);

    // A same-edge load to the start address is forwarded straight into the MIR.
    assign fetch_word = (store_we && (ld_addr == nxt)) ? ld_data : store[nxt];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
        if (!reset_n) state <= HALTED;
        else          state <= state_nxt;
    end

    // Next-state and next-address logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nxt = state;
        nxt       = upc;
        advance   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        ovf       = 1'b0;
        unf       = 1'b0;
        unique case (state)
            HALTED: begin
                if (start) begin
                    state_nxt = RUN;
                    nxt       = start_addr;
                    advance   = 1'b1;
                end
            end
            RUN: begin
                if (!stall) begin
                    advance = 1'b1;
                    unique case (mir_ns)
                        NS_INC:  nxt = upc_inc;
                        NS_JMP:  nxt = mir_cr;
                        NS_CBR:  nxt = cond ? mir_cr : upc_inc;
                        NS_DISP: nxt = dispatch_addr;
                        NS_CALL: begin
                            nxt = mir_cr;
                            if (sp == SP_FULL) ovf  = 1'b1;
                            else               push = 1'b1;
                        end
                        NS_RET: begin
                            if (sp == '0) begin
                                unf = 1'b1;
                                nxt = upc_inc;
                            end else begin
                                pop = 1'b1;
                                nxt = stack[sp_dec];
                            end
                        end
                        NS_WAIT: nxt = cond ? upc_inc : upc;
                        NS_HALT: begin
                            state_nxt = HALTED;
                            advance   = 1'b0;
                        end
                    endcase
                end
            end
        endcase
    end

    // Sequencer datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upc <= '0;
            mir <= '0;
            sp  <= '0;
            err <= '0;
        end else begin
            if (advance) begin
                upc <= nxt;
                mir <= fetch_word;
            end
            if (launch)    sp <= '0;
            else if (push) sp <= sp + SP_W'(1);
            else if (pop)  sp <= sp_dec;
            if (launch) err <= '0;
            else        err <= err | {ld_run, unf, ovf};
        end
    end

    // NOTE: storage arrays carry no reset; only their control state is reset.
    always_ff @(posedge clk) begin
        if (store_we) store[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (push) stack[sp] <= upc_inc;
    end

    // Outputs.
    always_comb begin
        halted = (state == HALTED);
        ctrl   = (state == RUN) ? mir_ctrl : '0;
    end

endmodule
